// File: rtl/aes_key_expand_ctrl.sv
// AES-128 key schedule sequencer: streams round keys 0..ROUNDS under backpressure.
// Optional round-key store enabled by defining AES_KEY_STORE_EN.
module aes_key_shedualing (
  input  logic [127:0] key_i,
  input  logic [7:0]   key_rcon_i,
  output logic [127:0] key_next_o,
  output logic [7:0]   key_rcon_o
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // Inverse as x^254 = prod x^(2^i), i=1..7, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    logic [7:0] b;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    b = r;
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sw, tw;
  logic [31:0] n0, n1, n2, n3;

  assign w0 = key_i[127:96];
  assign w1 = key_i[95:64];
  assign w2 = key_i[63:32];
  assign w3 = key_i[31:0];

  assign sw = {sbox(w3[23:16]), sbox(w3[15:8]),
               sbox(w3[7:0]),   sbox(w3[31:24])};
  assign tw = sw ^ {key_rcon_i, 24'h000000};

  assign n0 = w0 ^ tw;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_next_o = {n0, n1, n2, n3};
  assign key_rcon_o = {key_rcon_i[6:0], 1'b0}
                    ^ (key_rcon_i[7] ? 8'h1b : 8'h00);

endmodule

module aes_key_expand_ctrl #(
  parameter int ROUNDS = 10
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         key_valid_i,
  input  logic [127:0] key_i,
  output logic         key_ready_o,
  input  logic         abort_i,
  output logic [127:0] round_key_o,
  output logic [3:0]   round_idx_o,
  output logic         round_key_valid_o,
  input  logic         round_key_ready_i,
  output logic         busy_o,
  output logic         done_o
`ifdef AES_KEY_STORE_EN
  ,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_key_o
`endif
);

  localparam logic [3:0] LAST = 4'(ROUNDS);

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  state_e       state_q, state_d;
  logic [127:0] key_q, key_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   idx_q, idx_d;
  logic         done_q, done_d;

  logic [127:0] key_nx;
  logic [7:0]   rcon_nx;
  logic         hs;

  aes_key_shedualing u_sched (
    .key_i      (key_q),
    .key_rcon_i (rcon_q),
    .key_next_o (key_nx),
    .key_rcon_o (rcon_nx)
  );

  assign hs = (state_q == EMIT) && round_key_ready_i;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      key_q   <= '0;
      rcon_q  <= 8'h01;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      rcon_q  <= rcon_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    rcon_d  = rcon_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (key_valid_i) begin
          key_d   = key_i;
          rcon_d  = 8'h01;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        // Abort outranks the final handshake, so no done pulse.
        if (abort_i) begin
          state_d = IDLE;
        end else if (round_key_ready_i) begin
          if (idx_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            key_d  = key_nx;
            rcon_d = rcon_nx;
            idx_d  = idx_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_ready_o       = (state_q == IDLE);
  assign busy_o            = (state_q == EMIT);
  assign round_key_valid_o = (state_q == EMIT);
  assign round_key_o       = key_q;
  assign round_idx_o       = idx_q;
  assign done_o            = done_q;

`ifdef AES_KEY_STORE_EN
  logic [127:0] store_q [ROUNDS+1];

  always_ff @(posedge clk) begin
    if (hs) store_q[idx_q] <= key_q;
  end

  assign rd_key_o = (rd_idx_i > LAST) ? '0 : store_q[rd_idx_i];
`else
  logic unused_hs;
  assign unused_hs = hs;
`endif

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Directed bench for aes_key_expand_ctrl: zero and FIPS-197 keys,
// backpressure, abort, async reset and back-to-back key loads.
module tb_aes_key_expand_ctrl;

  logic         clk;
  logic         nreset;
  logic         key_valid_i;
  logic [127:0] key_i;
  logic         key_ready_o;
  logic         abort_i;
  logic [127:0] round_key_o;
  logic [3:0]   round_idx_o;
  logic         round_key_valid_o;
  logic         round_key_ready_i;
  logic         busy_o;
  logic         done_o;
`ifdef AES_KEY_STORE_EN
  logic [3:0]   rd_idx_i;
  logic [127:0] rd_key_o;
`endif

  int vectors;
  int miscompares;

  localparam logic [127:0] FK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] JNK = 128'hdeadbeef00112233445566778899aabb;

  localparam logic [127:0] ZT [11] = '{
    128'h00000000000000000000000000000000,
    128'h62636363626363636263636362636363,
    128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
    128'h90973450696ccffaf2f457330b0fac99,
    128'hee06da7b876a1581759e42b27e91ee2b,
    128'h7f2e2b88f8443e098dda7cbbf34b9290,
    128'hec614b851425758c99ff09376ab49ba7,
    128'h217517873550620bacaf6b3cc61bf09b,
    128'h0ef903333ba9613897060a04511dfa9f,
    128'hb1d4d8e28a7db9da1d7bb3de4c664941,
    128'hb4ef5bcb3e92e21123e951cf6f8f188e
  };

  aes_key_expand_ctrl #(.ROUNDS(10)) dut (
    .clk               (clk),
    .nreset            (nreset),
    .key_valid_i       (key_valid_i),
    .key_i             (key_i),
    .key_ready_o       (key_ready_o),
    .abort_i           (abort_i),
    .round_key_o       (round_key_o),
    .round_idx_o       (round_idx_o),
    .round_key_valid_o (round_key_valid_o),
    .round_key_ready_i (round_key_ready_i),
    .busy_o            (busy_o),
    .done_o            (done_o)
`ifdef AES_KEY_STORE_EN
    ,
    .rd_idx_i          (rd_idx_i),
    .rd_key_o          (rd_key_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int   ex;
    logic stall;
    logic seen;
    logic [127:0] pk;
    logic [3:0]   pi;

    vectors           = 0;
    miscompares       = 0;
    nreset            = 1'b0;
    key_valid_i       = 1'b0;
    key_i             = '0;
    abort_i           = 1'b0;
    round_key_ready_i = 1'b0;
`ifdef AES_KEY_STORE_EN
    rd_idx_i          = '0;
`endif
    #3;
    chk("rst_kready", key_ready_o, 1);
    chk("rst_valid", round_key_valid_o, 0);
    chk("rst_key", round_key_o, 0);
    chk("rst_idx", round_idx_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    #4 nreset = 1'b1;
    tick();

    // zero key, ready held high
    key_valid_i       = 1'b1;
    key_i             = '0;
    round_key_ready_i = 1'b1;
    tick();
    key_valid_i = 1'b0;
    for (int r = 0; r <= 10; r++) begin
      chk("z_valid", round_key_valid_o, 1);
      chk("z_idx", round_idx_o, r);
      chk("z_key", round_key_o, ZT[r]);
      chk("z_done", done_o, 0);
      tick();
    end
    chk("z_done_pulse", done_o, 1);
    chk("z_kready", key_ready_o, 1);
    chk("z_busy", busy_o, 0);
`ifdef AES_KEY_STORE_EN
    rd_idx_i = 4'd2;
    #1 chk("st_rd2", rd_key_o, ZT[2]);
    rd_idx_i = 4'd11;
    #1 chk("st_rd11", rd_key_o, 0);
`endif

    // FIPS key offered in the done cycle; junk key held during EMIT
    key_valid_i = 1'b1;
    key_i       = FK;
    tick();
    key_i = JNK;
    for (int r = 0; r <= 10; r++) begin
      chk("f_idx", round_idx_o, r);
      chk("f_kready", key_ready_o, 0);
      if (r == 0)  chk("f_key0", round_key_o, FK);
      if (r == 1)  chk("f_key1", round_key_o, F1);
      if (r == 10) begin
        chk("f_key10", round_key_o, F10);
        key_valid_i = 1'b0;
      end
      tick();
    end
    chk("f_done_pulse", done_o, 1);
    tick();
    chk("f_done_clear", done_o, 0);
    chk("f_idle", round_key_valid_o, 0);

    // random backpressure, zero key
    key_valid_i       = 1'b1;
    key_i             = '0;
    round_key_ready_i = 1'b0;
    tick();
    key_valid_i = 1'b0;
    ex    = 0;
    stall = 1'b0;
    seen  = 1'b0;
    pk    = '0;
    pi    = '0;
    for (int c = 0; c < 300 && !seen; c++) begin
      if (done_o) begin
        seen = 1'b1;
      end else begin
        if (stall) begin
          chk("rnd_hold_key", round_key_o, pk);
          chk("rnd_hold_idx", round_idx_o, pi);
        end
        round_key_ready_i = 1'($urandom_range(0, 1));
        if (round_key_valid_o && round_key_ready_i) begin
          chk("rnd_idx", round_idx_o, ex);
          chk("rnd_key", round_key_o, ZT[ex > 10 ? 10 : ex]);
          ex++;
        end
        stall = round_key_valid_o && !round_key_ready_i;
        pk    = round_key_o;
        pi    = round_idx_o;
        tick();
      end
    end
    chk("rnd_done_seen", seen, 1);
    chk("rnd_count", ex, 11);
    round_key_ready_i = 1'b1;
    tick();

    // abort at round 4
    key_valid_i = 1'b1;
    key_i       = '0;
    tick();
    key_valid_i = 1'b0;
    for (int r = 0; r < 4; r++) tick();
    chk("ab_idx4", round_idx_o, 4);
    abort_i = 1'b1;
    tick();
    chk("ab_kready", key_ready_o, 1);
    chk("ab_valid", round_key_valid_o, 0);
    chk("ab_done", done_o, 0);
    // abort still high in IDLE must not block the next key
    key_valid_i = 1'b1;
    tick();
    abort_i     = 1'b0;
    key_valid_i = 1'b0;
    chk("ab_re_valid", round_key_valid_o, 1);
    chk("ab_re_idx0", round_idx_o, 0);
    chk("ab_re_key0", round_key_o, ZT[0]);
    chk("ab_no_done", done_o, 0);
    tick();
    chk("ab_re_key1", round_key_o, ZT[1]);
    for (int r = 1; r < 10; r++) tick();
    chk("ab_re_idx10", round_idx_o, 10);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("ab_final_done", done_o, 0);
    chk("ab_final_kready", key_ready_o, 1);
    tick();
    chk("ab_final_done2", done_o, 0);

    // async reset mid-expansion
    key_valid_i = 1'b1;
    key_i       = FK;
    tick();
    key_valid_i = 1'b0;
    tick();
    tick();
    chk("ar_idx2", round_idx_o, 2);
    #2 nreset = 1'b0;
    #1;
    chk("ar_key", round_key_o, 0);
    chk("ar_idx", round_idx_o, 0);
    chk("ar_valid", round_key_valid_o, 0);
    chk("ar_kready", key_ready_o, 1);
    chk("ar_busy", busy_o, 0);
    chk("ar_done", done_o, 0);
    #2 nreset = 1'b1;
    tick();
    chk("ar_done_after", done_o, 0);
    chk("ar_idle", round_key_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_key_expand_ctrl.md
# aes_key_expand_ctrl

Sequencer for the combinational `aes_key_shedualing` round function. It accepts a 128-bit cipher key through a valid/ready handshake, then steps the key schedule once per accepted output beat. Round keys 0..ROUNDS stream out in order under downstream backpressure. It sits between the key-load interface and the AES round datapath, and owns the key and rcon state registers that the combinational expansion function lacks.

## Interface
Parameters:
- `ROUNDS`, default 10: index of the last round key emitted. Legal range 1..10; 10 gives full AES-128.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `nreset` in 1: asynchronous, active-low reset.
- `key_valid_i` in 1: a cipher key is offered on `key_i`.
- `key_i` in 128: cipher key (round key 0).
- `key_ready_o` out 1: controller is idle and can accept a key.
- `abort_i` in 1: synchronous abort of the expansion in progress.
- `round_key_o` out 128: current round key.
- `round_idx_o` out 4: index of `round_key_o`, range 0..ROUNDS.
- `round_key_valid_o` out 1: `round_key_o` and `round_idx_o` are valid.
- `round_key_ready_i` in 1: consumer accepts the current round key.
- `busy_o` out 1: an expansion is in progress.
- `done_o` out 1: single-cycle pulse after the last round key is accepted.

## Operation
- Instantiates one `aes_key_shedualing`, with `key_i` driven from `key_q` and `key_rcon_i` from `rcon_q`. Its outputs `key_next_o` and `key_rcon_o` are the next-state values.
- States:
  - **IDLE**
    - `key_ready_o`=1, `busy_o`=0, `round_key_valid_o`=0.
    - On `key_valid_i`: load `key_q`←`key_i`, `rcon_q`←8'h01, `idx`←0, then go to EMIT.
  - **EMIT**
    - `round_key_valid_o`=1, `busy_o`=1, `round_key_o`=`key_q`, `round_idx_o`=`idx`.
    - On `round_key_ready_i` with `idx`<ROUNDS: `key_q`←`key_next_o`, `rcon_q`←`key_rcon_o`, `idx`←`idx`+1.
    - On `round_key_ready_i` with `idx`==ROUNDS: go to IDLE and assert `done_o` for the following cycle.
    - Without `round_key_ready_i`: all outputs hold stable.
- `abort_i` in EMIT returns the block to IDLE on the next edge with no `done_o`. If `abort_i` coincides with the final handshake, abort wins: no `done_o`, although the beat counts as consumed.
- `abort_i` in IDLE has no effect.
- `key_valid_i` while busy is ignored, because `key_ready_o`=0.
- `rcon_q` is 8 bits and follows the xtime sequence 01,02,04,...,80,1b,36. No rcon state survives beyond round 10.

## Timing
- Reset values: `key_q`=0, `rcon_q`=8'h01, `idx`=0, state IDLE.
  - Outputs at reset: `key_ready_o`=1, `round_key_valid_o`=0, `round_key_o`=0, `round_idx_o`=0, `busy_o`=0, `done_o`=0.
- Key acceptance at edge N puts round key 0 valid in cycle N+1.
- With `round_key_ready_i` held high, round keys 0..ROUNDS appear on consecutive cycles N+1..N+1+ROUNDS.
- `done_o`=1 and `key_ready_o`=1 in cycle N+2+ROUNDS. A new key may be accepted in that same cycle (back-to-back, zero bubbles beyond the done cycle).
- Asserting `nreset` mid-expansion forces the reset values immediately, independent of `clk`. No `done_o` is produced.

## Configuration
- `AES_KEY_STORE_EN` defined:
  - Adds an (ROUNDS+1)×128 register file, written on each EMIT handshake at index `idx`.
  - Adds ports `rd_idx_i` in 4 and `rd_key_o` out 128. Read is combinational. Contents persist until overwritten by the next expansion.
  - `rd_idx_i`>ROUNDS returns 0.
  - Storage is not reset: contents are undefined until written.
- `AES_KEY_STORE_EN` undefined: there is no storage and these ports do not exist.

## Test plan
- Reset, then key 128'h0 with ready held high → `round_idx_o` 0..10 on 11 consecutive cycles.
  - Round 1 = 62636363626363636263636362636363.
  - Round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - `done_o` pulses one cycle after round 10.
- Key 2b7e151628aed2a6abf7158809cf4f3c → round 1 = a0fafe1788542cb123a339392a6c7605, round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Random `round_key_ready_i` (50%) → outputs stable while not ready; the same 11 keys appear in order with no skips or duplicates.
- `abort_i` at round 4 → IDLE next cycle, no `done_o`, `key_ready_o`=1. A following zero key restarts at round 0 with `rcon_q`=01.
- `nreset` pulsed low mid-expansion, asynchronous to `clk` → all outputs take their reset values immediately.
  - `key_valid_i` held high during EMIT is ignored; a second key offered in the `done_o` cycle is accepted.
- With `AES_KEY_STORE_EN` defined: after the zero-key run, `rd_idx_i`=2 returns 9b9898c9f9fbfbaa9b9898c9f9fbfbaa, and `rd_idx_i`=11 returns 0.
